// File: rtl/sobel_edge_stage.sv
// sobel_edge_stage: three-stage pipelined 3x3 Sobel gradient magnitude with
// border masking, thresholded edge bit and end-of-frame marker.
//
// Valid semantics: win_valid qualifies P1..P9 in the cycle it is high and the
// stage always accepts (no ready). edge_valid is win_valid delayed by exactly
// three register stages; edge_mag/edge_bin/frame_done are 0 whenever
// edge_valid is 0.
module sobel_edge_stage #(
  parameter int data_width = 8,
  parameter int line_width = 317,
  parameter int line_count = 240
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  win_valid,
  input  logic [data_width-1:0] P1,
  input  logic [data_width-1:0] P2,
  input  logic [data_width-1:0] P3,
  input  logic [data_width-1:0] P4,
  input  logic [data_width-1:0] P5,
  input  logic [data_width-1:0] P6,
  input  logic [data_width-1:0] P7,
  input  logic [data_width-1:0] P8,
  input  logic [data_width-1:0] P9,
  input  logic [data_width-1:0] threshold,
  output logic                  edge_valid,
  output logic [data_width-1:0] edge_mag,
  output logic                  edge_bin,
  output logic                  frame_done
);

  // Partial sums are unsigned SW bits; signed differences and the |Gx|+|Gy|
  // sum are DW bits.
  localparam int SW    = data_width + 2;
  localparam int DW    = data_width + 3;
  localparam int COL_W = $clog2(line_width);
  localparam int ROW_W = $clog2(line_count);

  // Window position of the next accepted window.
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;

  // Stage 1 registers.
  logic          s1_valid, s1_mask, s1_last;
  logic [SW-1:0] s1_x_pos, s1_x_neg, s1_y_pos, s1_y_neg;

  // Stage 2 registers.
  logic          s2_valid, s2_mask, s2_last;
  logic [SW-1:0] s2_abs_x, s2_abs_y;

  // Combinational values feeding the stage registers.
  logic [SW-1:0]         x_pos, x_neg, y_pos, y_neg;
  logic signed [DW-1:0]  diff_x, diff_y;
  logic [SW-1:0]         abs_x, abs_y;
  logic [DW-1:0]         mag_sum;
  logic [data_width-1:0] mag_sat;
  logic                  col_last, row_last, border;

  // P5 does not contribute to either Sobel kernel.
  logic unused_center;
  assign unused_center = ^P5;

  // Position decode on the current (pre-advance) counter values.
  always_comb begin
    col_last = (col == COL_W'(line_width - 1));
    row_last = (row == ROW_W'(line_count - 1));
    border   = (col < COL_W'(2)) || (row < ROW_W'(2));
  end

  // Column/row counters advance only on accepted windows; both wrap together
  // at frame end.
  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (win_valid) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  // Stage 1 arithmetic: the four weighted column/row sums.
  always_comb begin
    x_pos = {2'b00, P3} + {1'b0, P6, 1'b0} + {2'b00, P9};
    x_neg = {2'b00, P1} + {1'b0, P4, 1'b0} + {2'b00, P7};
    y_pos = {2'b00, P7} + {1'b0, P8, 1'b0} + {2'b00, P9};
    y_neg = {2'b00, P1} + {1'b0, P2, 1'b0} + {2'b00, P3};
  end

  // Stage 1 register: partial sums plus valid, border mask and last flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_mask  <= 1'b0;
      s1_last  <= 1'b0;
      s1_x_pos <= '0;
      s1_x_neg <= '0;
      s1_y_pos <= '0;
      s1_y_neg <= '0;
    end else begin
      s1_valid <= win_valid;
      s1_mask  <= win_valid && border;
      s1_last  <= win_valid && col_last && row_last;
      s1_x_pos <= x_pos;
      s1_x_neg <= x_neg;
      s1_y_pos <= y_pos;
      s1_y_neg <= y_neg;
    end
  end

  // Stage 2 arithmetic: signed gradients and their magnitudes.
  always_comb begin
    diff_x = $signed({1'b0, s1_x_pos}) - $signed({1'b0, s1_x_neg});
    diff_y = $signed({1'b0, s1_y_pos}) - $signed({1'b0, s1_y_neg});
    abs_x  = diff_x[DW-1] ? SW'(-diff_x) : SW'(diff_x);
    abs_y  = diff_y[DW-1] ? SW'(-diff_y) : SW'(diff_y);
  end

  // Stage 2 register: |Gx|, |Gy| and forwarded flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_mask  <= 1'b0;
      s2_last  <= 1'b0;
      s2_abs_x <= '0;
      s2_abs_y <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_mask  <= s1_mask;
      s2_last  <= s1_last;
      s2_abs_x <= abs_x;
      s2_abs_y <= abs_y;
    end
  end

  // Stage 3 arithmetic: magnitude sum saturated to the pixel width.
  always_comb begin
    mag_sum = {1'b0, s2_abs_x} + {1'b0, s2_abs_y};
    mag_sat = (|mag_sum[DW-1:data_width]) ? '1 : mag_sum[data_width-1:0];
  end

  // Stage 3 register: masking, threshold compare and output drive.
  always_ff @(posedge clk) begin
    if (rst) begin
      edge_valid <= 1'b0;
      edge_mag   <= '0;
      edge_bin   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      edge_valid <= s2_valid;
      edge_mag   <= (s2_valid && !s2_mask) ? mag_sat : '0;
      edge_bin   <= s2_valid && !s2_mask && (mag_sat >= threshold);
      frame_done <= s2_valid && s2_last;
    end
  end

endmodule

// File: tb/tb_sobel_edge_stage.sv
// tb_sobel_edge_stage: randomized and directed checks of sobel_edge_stage on a
// small 8x4 frame against an arithmetic reference model with a 3-deep delay.
module tb_sobel_edge_stage;
  localparam int DW = 8;
  localparam int LW = 8;
  localparam int LC = 4;

  // Clock and reset.
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          win_valid = 1'b0;
  logic [DW-1:0] p [1:9];
  logic [DW-1:0] threshold = '0;
  logic          edge_valid;
  logic [DW-1:0] edge_mag;
  logic          edge_bin;
  logic          frame_done;

  sobel_edge_stage #(.data_width(DW), .line_width(LW), .line_count(LC)) dut (
    .clk(clk), .rst(rst), .win_valid(win_valid),
    .P1(p[1]), .P2(p[2]), .P3(p[3]), .P4(p[4]), .P5(p[5]),
    .P6(p[6]), .P7(p[7]), .P8(p[8]), .P9(p[9]),
    .threshold(threshold),
    .edge_valid(edge_valid), .edge_mag(edge_mag),
    .edge_bin(edge_bin), .frame_done(frame_done)
  );

  // Reference model state: one record per cycle, delayed three cycles.
  typedef struct packed {
    logic          v;
    logic [DW-1:0] mag;
    logic          mask;
    logic          last;
  } rec_t;
  rec_t pipe_q[$];
  int   m_col, m_row;
  int   checks = 0;
  int   errors = 0;
  // Output vector layout: {valid, mag[7:0], bin, done}.
  logic [10:0] got, exp_v;

  function automatic int model_mag();
    int gx, gy, s;
    gx = (int'(p[3]) + 2 * int'(p[6]) + int'(p[9])) - (int'(p[1]) + 2 * int'(p[4]) + int'(p[7]));
    gy = (int'(p[7]) + 2 * int'(p[8]) + int'(p[9])) - (int'(p[1]) + 2 * int'(p[2]) + int'(p[3]));
    s = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    return (s > 255) ? 255 : s;
  endfunction

  // Driver tasks.
  task automatic rand_window();
    for (int i = 1; i <= 9; i++) p[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic set_flat(input logic [DW-1:0] val);
    for (int i = 1; i <= 9; i++) p[i] = val;
  endtask

  task automatic set_vert(input logic [DW-1:0] val);
    for (int i = 1; i <= 9; i++) p[i] = '0;
    p[3] = val; p[6] = val; p[9] = val;
  endtask

  // One clock: drive, advance the model at the edge, sample at the negedge.
  task automatic send(input logic v, input logic r);
    rec_t rec, o;
    rst = r;
    win_valid = v;
    @(posedge clk);
    if (r) begin
      pipe_q.delete();
      rec = '0;
      pipe_q.push_back(rec);
      pipe_q.push_back(rec);
      m_col = 0;
      m_row = 0;
      exp_v = '0;
    end else begin
      rec.v    = v;
      rec.mag  = 8'(model_mag());
      rec.mask = (m_col < 2) || (m_row < 2);
      rec.last = (m_col == LW - 1) && (m_row == LC - 1);
      if (v) begin
        m_col++;
        if (m_col == LW) begin
          m_col = 0;
          m_row = (m_row + 1) % LC;
        end
      end
      pipe_q.push_back(rec);
      o = pipe_q.pop_front();
      exp_v = {o.v, (o.v && !o.mask) ? o.mag : 8'd0,
               o.v && !o.mask && (o.mag >= threshold), o.v && o.last};
    end
    @(negedge clk);
    got = {edge_valid, edge_mag, edge_bin, frame_done};
  endtask

  task automatic seek_interior();
    while (m_col < 2 || m_row < 2) begin
      rand_window();
      send(1'b1, 1'b0);
      checks++;
      if (got !== exp_v) begin errors++; $display("FAIL seek: got %h expected %h", got, exp_v); end
    end
  endtask

  // Scenario tasks.
  task automatic test_reset();
    threshold = 8'd10;
    repeat (2) begin
      rand_window();
      send(1'b1, 1'b1);
      checks++;
      if (got !== 11'h000) begin errors++; $display("FAIL reset_outputs: got %h expected 000", got); end
    end
    set_vert(8'd255);
    for (int k = 0; k < 3; k++) begin
      send(k == 0, 1'b0);
      checks++;
      if (got !== exp_v) begin errors++; $display("FAIL reset_model: got %h expected %h", got, exp_v); end
    end
    checks++;
    if (got !== {1'b1, 8'd0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL first_window_masked: got %h expected %h", got, {1'b1, 8'd0, 1'b0, 1'b0});
    end
  endtask

  task automatic test_flat();
    seek_interior();
    threshold = 8'd10;
    set_flat(8'd100);
    for (int k = 0; k < 3; k++) begin
      send(k == 0, 1'b0);
      checks++;
      if (got !== exp_v) begin errors++; $display("FAIL flat_model: got %h expected %h", got, exp_v); end
    end
    checks++;
    if (got[10:1] !== {1'b1, 8'd0, 1'b0}) begin
      errors++; $display("FAIL flat: got %h expected 200", got[10:1]);
    end
  endtask

  task automatic test_gradient();
    logic [7:0] vals [3];
    logic [7:0] thrs [3];
    logic [9:0] want [3];
    vals[0] = 8'd255; thrs[0] = 8'd40; want[0] = {1'b1, 8'd255, 1'b1};
    vals[1] = 8'd10;  thrs[1] = 8'd40; want[1] = {1'b1, 8'd40, 1'b1};
    vals[2] = 8'd10;  thrs[2] = 8'd41; want[2] = {1'b1, 8'd40, 1'b0};
    for (int c = 0; c < 3; c++) begin
      seek_interior();
      threshold = thrs[c];
      set_vert(vals[c]);
      for (int k = 0; k < 3; k++) begin
        send(k == 0, 1'b0);
        checks++;
        if (got !== exp_v) begin errors++; $display("FAIL gradient_model: got %h expected %h", got, exp_v); end
      end
      checks++;
      if (got[10:1] !== want[c]) begin
        errors++; $display("FAIL gradient_%0d: got %h expected %h", c, got[10:1], want[c]);
      end
    end
  endtask

  task automatic test_border();
    int masked_cnt = 0;
    send(1'b0, 1'b1);
    threshold = 8'd10;
    set_vert(8'd255);
    for (int i = 0; i < LW * LC + 2; i++) begin
      send(i < LW * LC, 1'b0);
      checks++;
      if (got !== exp_v) begin errors++; $display("FAIL border_model: got %h expected %h", got, exp_v); end
      if (got[10] && got[9:2] == 8'd0 && !got[1]) masked_cnt++;
    end
    checks++;
    if (masked_cnt != 2 * LW + 2 * (LC - 2)) begin
      errors++; $display("FAIL border_count: got %0d expected %0d", masked_cnt, 2 * LW + 2 * (LC - 2));
    end
  endtask

  task automatic test_frame();
    int sent = 0, drain = 0, valid_cnt = 0, done_cnt = 0, done_at = -1, guard = 0;
    logic v;
    send(1'b0, 1'b1);
    while ((sent < LW * LC || drain < 3) && guard < 400) begin
      guard++;
      v = (sent < LW * LC) && ($urandom_range(0, 2) != 0);
      rand_window();
      threshold = 8'($urandom_range(0, 255));
      send(v, 1'b0);
      if (v) sent++;
      else if (sent == LW * LC) drain++;
      checks++;
      if (got !== exp_v) begin errors++; $display("FAIL frame_model: got %h expected %h", got, exp_v); end
      if (got[10]) valid_cnt++;
      if (got[0]) begin done_cnt++; done_at = valid_cnt; end
    end
    checks++;
    if (valid_cnt != LW * LC || done_cnt != 1 || done_at != LW * LC) begin
      errors++;
      $display("FAIL frame_counts: got valid=%0d done=%0d at=%0d expected %0d 1 %0d",
               valid_cnt, done_cnt, done_at, LW * LC, LW * LC);
    end
  endtask

  task automatic test_reset_midline();
    int valid_cnt = 0, done_at = -1;
    send(1'b0, 1'b1);
    threshold = 8'd20;
    for (int i = 0; i < 5; i++) begin
      rand_window();
      send(1'b1, 1'b0);
      checks++;
      if (got !== exp_v) begin errors++; $display("FAIL midline_model: got %h expected %h", got, exp_v); end
    end
    rand_window();
    send(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      send(1'b0, 1'b0);
      if (got[10]) valid_cnt++;
    end
    checks++;
    if (valid_cnt != 0) begin errors++; $display("FAIL inflight_dropped: got %0d valid expected 0", valid_cnt); end
    for (int i = 0; i < LW * LC + 2; i++) begin
      rand_window();
      send(i < LW * LC, 1'b0);
      checks++;
      if (got !== exp_v) begin errors++; $display("FAIL restart_model: got %h expected %h", got, exp_v); end
      if (got[10]) valid_cnt++;
      if (got[0]) done_at = valid_cnt;
    end
    checks++;
    if (done_at != LW * LC) begin
      errors++; $display("FAIL restart_done: got window %0d expected %0d", done_at, LW * LC);
    end
  endtask

  // Sequencer and final report.
  initial begin
    set_flat(8'd0);
    test_reset();
    test_flat();
    test_gradient();
    test_border();
    test_frame();
    test_reset_midline();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end
endmodule
